// File: rtl/password_pkg.sv
// Shared types and sizing for the keypad password checker.
package password_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned CODE_LEN  = 4;
    localparam int unsigned MAX_DIGIT = 9;
    localparam int unsigned CODE_W    = DIGIT_W * CODE_LEN;
    localparam int unsigned COUNT_W   = 3;
    localparam int unsigned FAIL_W    = 2;
    localparam int unsigned TIMER_W   = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        FAIL    = 3'd4,
        LOCKOUT = 3'd5
    } state_e;

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the keypad key_down level. armed_q resets to 0 so a
// key already held when reset releases must be let go before it can register.
module key_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic key_down,
    output logic press_c
);

    logic armed_q;
    logic armed_d;

    always_comb begin
        armed_d = ~key_down;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

    assign press_c = key_down & armed_q;

endmodule

// File: rtl/password_checker.sv
// Four-digit keypad lock: collects BCD digits, compares against PASSWORD,
// opens the door for UNLOCK_CYCLES or locks out for LOCK_CYCLES after MAX_TRIES.
module password_checker
    import password_pkg::*;
#(
    parameter logic [15:0] PASSWORD      = 16'h1234,
    parameter int unsigned MAX_TRIES     = 3,
    parameter int unsigned UNLOCK_CYCLES = 100,
    parameter int unsigned LOCK_CYCLES   = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               key_down,
    input  logic               clear,
    output logic               unlock,
    output logic               err,
    output logic               alarm,
    output logic [COUNT_W-1:0] digit_count,
    output logic [FAIL_W-1:0]  fail_count
);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   buf_q, buf_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                press_c;
    logic                accept_c;
    logic [FAIL_W-1:0]   fail_inc_c;

    key_edge_detect u_key_edge_detect (
        .clk      (clk),
        .rst      (rst),
        .key_down (key_down),
        .press_c  (press_c)
    );

    assign accept_c   = press_c & digit_valid(digit);
    assign fail_inc_c = FAIL_W'(fail_q + FAIL_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    // Next-state and datapath updates; any path back to IDLE drops the entry.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE, ENTRY: begin
                if (clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (accept_c) begin
                    buf_d = {buf_q[CODE_W-DIGIT_W-1:0], digit};
                    cnt_d = COUNT_W'(cnt_q + COUNT_W'(1));
                    if (cnt_q == COUNT_W'(CODE_LEN - 1)) begin
                        state_d = CHECK;
                    end else begin
                        state_d = ENTRY;
                    end
                end
            end
            CHECK: begin
                if (buf_q == PASSWORD) begin
                    state_d = OPEN;
                    fail_d  = '0;
                    timer_d = TIMER_W'(UNLOCK_CYCLES - 1);
                end else begin
                    state_d = FAIL;
                end
            end
            OPEN: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = TIMER_W'(timer_q - TIMER_W'(1));
                end
            end
            FAIL: begin
                fail_d = fail_inc_c;
                if (fail_inc_c == FAIL_W'(MAX_TRIES)) begin
                    state_d = LOCKOUT;
                    timer_d = TIMER_W'(LOCK_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    fail_d  = '0;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = TIMER_W'(timer_q - TIMER_W'(1));
                end
            end
            default: begin
                state_d = IDLE;
                buf_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode registered state only.
    assign unlock      = (state_q == OPEN);
    assign alarm       = (state_q == LOCKOUT);
    assign err         = (state_q == FAIL) && (fail_inc_c != FAIL_W'(MAX_TRIES));
    assign digit_count = cnt_q;
    assign fail_count  = fail_q;

endmodule

// File: tb/tb_password_checker.sv
// Directed self-checking bench for password_checker with default parameters.
module tb_password_checker;
    import password_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       key_down = 1'b0;
    logic       clear = 1'b0;
    logic       unlock, err, alarm;
    logic [2:0] digit_count;
    logic [1:0] fail_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_start, t_end;

    password_checker dut (
        .clk         (clk),
        .rst         (rst),
        .digit       (digit),
        .key_down    (key_down),
        .clear       (clear),
        .unlock      (unlock),
        .err         (err),
        .alarm       (alarm),
        .digit_count (digit_count),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic press(input logic [3:0] d);
        digit    = d;
        key_down = 1'b1;
        repeat (3) tick();
        key_down = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_fall(input bit sel_alarm, input int bound, output int end_cyc);
        int n = 0;
        while ((sel_alarm ? alarm : unlock) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) check("wait_timeout", 32'd1, 32'd0);
        end_cyc = cyc;
    endtask

    initial begin
        tick();
        check("rst_unlock", 32'(unlock), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_digit_count", 32'(digit_count), 32'd0);
        check("rst_fail_count", 32'(fail_count), 32'd0);

        // Correct code 1234
        press(4'd1); press(4'd2); press(4'd3);
        check("ok_count3", 32'(digit_count), 32'd3);
        digit = 4'd4; key_down = 1'b1;
        tick();
        check("ok_check_unlock0", 32'(unlock), 32'd0);
        tick();
        check("ok_unlock_n2", 32'(unlock), 32'd1);
        check("ok_err", 32'(err), 32'd0);
        check("ok_alarm", 32'(alarm), 32'd0);
        t_start = cyc;
        key_down = 1'b0;
        wait_fall(1'b0, 300, t_end);
        check("ok_unlock_len", 32'(t_end - t_start), 32'd100);
        check("ok_count_idle", 32'(digit_count), 32'd0);

        // Wrong code 1235
        press(4'd1); press(4'd2); press(4'd3);
        digit = 4'd5; key_down = 1'b1;
        tick();
        check("bad_err_n1", 32'(err), 32'd0);
        tick();
        check("bad_err_n2", 32'(err), 32'd1);
        check("bad_unlock", 32'(unlock), 32'd0);
        tick();
        check("bad_err_n3", 32'(err), 32'd0);
        check("bad_fail_count", 32'(fail_count), 32'd1);
        check("bad_digit_count", 32'(digit_count), 32'd0);
        key_down = 1'b0;
        repeat (2) tick();

        // Lockout after three wrong codes
        do_reset();
        for (int k = 0; k < 3; k++) begin
            press(4'd9); press(4'd9); press(4'd9);
            digit = 4'd9; key_down = 1'b1;
            tick(); tick();
            if (k < 2) check("lock_err_pulse", 32'(err), 32'd1);
            else       check("lock_no_err", 32'(err), 32'd0);
            tick();
            key_down = 1'b0;
            if (k < 2) begin
                check("lock_fail_count", 32'(fail_count), 32'(k + 1));
                repeat (2) tick();
            end
        end
        check("lock_alarm_on", 32'(alarm), 32'd1);
        check("lock_unlock", 32'(unlock), 32'd0);
        t_start = cyc;
        tick();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("lock_presses_ignored", 32'(digit_count), 32'd4);
        check("lock_still_alarm", 32'(alarm), 32'd1);
        wait_fall(1'b1, 2000, t_end);
        check("lock_alarm_len", 32'(t_end - t_start), 32'd1000);
        check("lock_fail_cleared", 32'(fail_count), 32'd0);
        check("lock_count_cleared", 32'(digit_count), 32'd0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("lock_then_unlock", 32'(unlock), 32'd1);
        wait_fall(1'b0, 300, t_end);

        // Held key then invalid digit
        digit = 4'd1; key_down = 1'b1;
        repeat (20) tick();
        key_down = 1'b0;
        check("held_count", 32'(digit_count), 32'd1);
        repeat (2) tick();
        press(4'd12);
        check("invalid_count", 32'(digit_count), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_after_invalid", 32'(digit_count), 32'd0);

        // Clear wins over a simultaneous press
        press(4'd1); press(4'd2);
        check("clr_count2", 32'(digit_count), 32'd2);
        digit = 4'd3; key_down = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count0", 32'(digit_count), 32'd0);
        key_down = 1'b0;
        repeat (2) tick();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("clr_then_unlock", 32'(unlock), 32'd1);

        // Asynchronous reset mid-OPEN
        #3 rst = 1'b1;
        #1;
        check("arst_unlock_now", 32'(unlock), 32'd0);
        check("arst_alarm_now", 32'(alarm), 32'd0);
        #10 rst = 1'b0;
        tick();
        check("arst_state_idle", 32'(dut.state_q), 32'(IDLE));
        check("arst_unlock", 32'(unlock), 32'd0);
        check("arst_count", 32'(digit_count), 32'd0);

        // Key held across reset release
        digit = 4'd5; key_down = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("held_reset_count", 32'(digit_count), 32'd0);
        key_down = 1'b0;
        repeat (2) tick();
        press(4'd5);
        check("after_release_count", 32'(digit_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/password_checker.md
PASSWORD_CHECKER -- requirements
Module: password_checker

Interface
REQ-001 SHALL take parameter PASSWORD, default 16'h1234: four BCD digits; [15:12] is the first digit entered, [3:0] the last.
REQ-002 SHALL take parameter MAX_TRIES, default 3: consecutive failures that cause lockout; legal range 1-3.
REQ-003 SHALL take parameter UNLOCK_CYCLES, default 100: cycles that unlock stays high; must be ≥1.
REQ-004 SHALL take parameter LOCK_CYCLES, default 1000: cycles that alarm stays high in lockout; must be ≥1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port digit, input, 4 bits: encoded keypad digit from the button encoder; legal values are 0-9.
REQ-008 SHALL have port key_down, input, 1 bit: level signal, high while exactly one digit button is held.
REQ-009 SHALL have port clear, input, 1 bit: synchronous request to discard the partial entry.
REQ-010 SHALL have port unlock, output, 1 bit: high while the door is open.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse on a wrong code that does not cause lockout.
REQ-012 SHALL have port alarm, output, 1 bit: high throughout lockout.
REQ-013 SHALL have port digit_count, output, 3 bits: number of digits buffered, 0-4.
REQ-014 SHALL have port fail_count, output, 2 bits: current count of consecutive failures.

Function
REQ-015 SHALL accept a key press only on the first cycle key_down is high after a cycle it was low.
- The press-detect register updates in every state.
- A key held across a state change does not register again until it is released.
REQ-016 SHALL sample digit in the same cycle the press is detected.
REQ-017 SHALL ignore a press whose digit value is greater than 9; such a press is not counted.
REQ-018 SHALL implement FSM states IDLE, ENTRY, CHECK, OPEN, FAIL and LOCKOUT; the state register is registered.
REQ-019 SHALL behave as follows in IDLE and ENTRY:
- Each accepted press shifts the digit into a 16-bit buffer and increments digit_count.
- The first press moves IDLE to ENTRY.
- The 4th accepted press (at cycle N) moves the FSM to CHECK at N+1.
REQ-020 SHALL compare the full 16-bit buffer with PASSWORD in CHECK (one cycle):
- Match: go to OPEN at N+2.
- Mismatch: go to FAIL at N+2.
REQ-021 SHALL drive unlock high from N+2 for exactly UNLOCK_CYCLES cycles, clear fail_count on entering OPEN, then return to IDLE.
REQ-022 SHALL, in FAIL (one cycle):
- Increment fail_count.
- If the new count equals MAX_TRIES: go to LOCKOUT.
- Otherwise: pulse err high for that one cycle and go to IDLE.
REQ-023 SHALL, in LOCKOUT, hold alarm high for exactly LOCK_CYCLES cycles, then clear fail_count and return to IDLE.
REQ-024 SHALL ignore key presses and clear in CHECK, OPEN, FAIL and LOCKOUT.
REQ-025 SHALL, when clear is high in IDLE or ENTRY, zero the buffer and digit_count, go to IDLE, and leave fail_count unchanged.
REQ-026 SHALL give clear priority when clear and an accepted press occur in the same cycle; the digit is discarded.
REQ-027 SHALL clear the buffer and digit_count on every return to IDLE.
REQ-028 SHALL use one 32-bit down-counter shared between OPEN and LOCKOUT, loaded on state entry.
REQ-029 SHALL drive all outputs from registers or decode them from state only; no output depends combinationally on an input.

Reset
REQ-030 SHALL, while rst is high, force state to IDLE and set the buffer, digit_count, fail_count, timer and press-detect register to 0, regardless of clk.
REQ-031 SHALL hold unlock, err and alarm at 0 during reset.
REQ-032 SHALL abort any operation in progress when reset is asserted, including OPEN and LOCKOUT, with no residual output.
REQ-033 SHALL NOT accept a key held across reset deassertion until it is released.

Structure
REQ-034 SHALL place the FSM state enum, DIGIT_W=4, CODE_LEN=4 and MAX_DIGIT=9 in a shared package, password_pkg.
REQ-035 SHALL contain one sub-module, key_edge_detect, which produces a registered rising-edge pulse from key_down.

Verification
REQ-036 SHALL cover a correct code:
- Stimulus: presses 1,2,3,4, each held 3 cycles and released 2 cycles.
- Response: unlock high 2 cycles after the 4th press edge, for exactly 100 cycles; err and alarm stay 0.
REQ-037 SHALL cover a wrong code:
- Stimulus: presses 1,2,3,5.
- Response: err pulses for 1 cycle at N+2; fail_count=1; unlock stays 0; digit_count returns to 0.
REQ-038 SHALL cover lockout:
- Stimulus: three wrong codes.
- Response: alarm high for 1000 cycles; presses during lockout are ignored; afterwards fail_count=0 and code 1234 then unlocks.
REQ-039 SHALL cover held key and invalid digit:
- Stimulus: key_down held 20 cycles with digit=1, then a press with digit=12.
- Response: digit_count=1 after both.
REQ-040 SHALL cover clear:
- Stimulus: presses 1,2; clear together with a press of 3; then presses 1,2,3,4.
- Response: digit_count=0 after the clear; the final entry unlocks.
REQ-041 SHALL cover asynchronous reset:
- Stimulus: rst pulsed mid-OPEN, between clock edges.
- Response: unlock falls immediately; state is IDLE after release.
